// File: rtl/div_seq.sv
// div_seq: iterative 32-bit divide sequencer for RISC-V DIV/DIVU/REM/REMU.
// Restoring division, one quotient bit per cycle. Every subtraction and
// negation is done on an external adder driven through o_add_* / i_add_*.
//
// Ports:
//   i_clk, i_reset      clock (rising edge), asynchronous active-high reset
//   i_flush             synchronous kill of the in-flight operation
//   i_valid, o_ready    request handshake (o_ready high only in IDLE)
//   i_op                00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_a, i_b            dividend, divisor
//   o_valid, i_ready    result handshake; o_result held while i_ready low
//   o_result            quotient or remainder (registered)
//   o_add_a/b/c         adder operands and carry-in (0 when adder unused)
//   i_add_sum/carry     combinational adder return
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_add_a,
  output logic [WIDTH-1:0] o_add_b,
  output logic             o_add_c,
  input  logic [WIDTH-1:0] i_add_sum,
  input  logic             i_add_carry
);

  if (WIDTH != 32) begin : g_width_check
    $error("div_seq: only WIDTH=32 is supported");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX, S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] r_q;     // partial remainder
  logic [WIDTH-1:0] n_q;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] d_q;     // divisor
  logic [4:0]       cnt_q;
  logic [1:0]       op_q;
  logic             sa_q;
  logic             sb_q;

  logic             in_signed;
  logic             in_sa;
  logic             in_sb;
  logic             div_zero;
  logic             sig_ovf;
  logic             q_bit;
  logic [WIDTH-1:0] shifted_r;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] n_next;
  logic             need_fix;

  assign o_ready   = (state == S_IDLE);

  assign in_signed = ~i_op[0];
  assign in_sa     = in_signed & i_a[WIDTH-1];
  assign in_sb     = in_signed & i_b[WIDTH-1];
  assign div_zero  = (i_b == '0);
  assign sig_ovf   = in_signed && (i_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_b == '1);

  // Shifted remainder is conceptually 33 bits; its dropped MSB (r_q[31])
  // guarantees it exceeds the divisor, so it forces the quotient bit.
  assign shifted_r = {r_q[WIDTH-2:0], n_q[WIDTH-1]};
  assign q_bit     = r_q[WIDTH-1] | i_add_carry;
  assign r_next    = q_bit ? i_add_sum : shifted_r;
  assign n_next    = {n_q[WIDTH-2:0], q_bit};

  // REM takes the dividend's sign; DIV is negative when signs differ.
  assign need_fix  = op_q[1] ? sa_q : (sa_q ^ sb_q);

  always_comb begin
    o_add_a = '0;
    o_add_b = '0;
    o_add_c = 1'b0;
    unique case (state)
      S_NEG_A: begin
        o_add_b = ~n_q;
        o_add_c = 1'b1;
      end
      S_NEG_B: begin
        o_add_b = ~d_q;
        o_add_c = 1'b1;
      end
      S_ITER: begin
        o_add_a = shifted_r;
        o_add_b = ~d_q;
        o_add_c = 1'b1;
      end
      S_FIX: begin
        o_add_b = op_q[1] ? ~r_q : ~n_q;
        o_add_c = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_IDLE;
      r_q      <= '0;
      n_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= '0;
    end else if (i_flush) begin
      state   <= S_IDLE;
      o_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_valid) begin
            op_q <= i_op;
            if (div_zero) begin
              o_result <= i_op[1] ? i_a : '1;
              o_valid  <= 1'b1;
              state    <= S_DONE;
            end else if (sig_ovf) begin
              o_result <= i_op[1] ? '0 : i_a;
              o_valid  <= 1'b1;
              state    <= S_DONE;
            end else begin
              n_q   <= i_a;
              d_q   <= i_b;
              r_q   <= '0;
              cnt_q <= '0;
              sa_q  <= in_sa;
              sb_q  <= in_sb;
              if (in_sa)      state <= S_NEG_A;
              else if (in_sb) state <= S_NEG_B;
              else            state <= S_ITER;
            end
          end
        end
        S_NEG_A: begin
          n_q   <= i_add_sum;
          state <= sb_q ? S_NEG_B : S_ITER;
        end
        S_NEG_B: begin
          d_q   <= i_add_sum;
          state <= S_ITER;
        end
        S_ITER: begin
          r_q   <= r_next;
          n_q   <= n_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            if (need_fix) begin
              state <= S_FIX;
            end else begin
              // Result register loads the final-iteration values directly
              // so o_valid can rise on the same edge.
              o_result <= op_q[1] ? r_next : n_next;
              o_valid  <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_FIX: begin
          o_result <= i_add_sum;
          o_valid  <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_c;
  logic [31:0] add_sum;
  logic        add_carry;

  logic        hold = 1'b0;
  logic        rand_ready = 1'b0;
  logic        rnd_bit = 1'b1;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  div_seq #(.WIDTH(32)) dut (
    .i_clk(clk), .i_reset(reset), .i_flush(flush),
    .i_valid(in_valid), .o_ready(in_ready), .i_op(op), .i_a(a), .i_b(b),
    .o_valid(out_valid), .i_ready(out_ready), .o_result(result),
    .o_add_a(add_a), .o_add_b(add_b), .o_add_c(add_c),
    .i_add_sum(add_sum), .i_add_carry(add_carry)
  );

  // Behavioural stand-in for the external adder.
  assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_c};

  assign out_ready = rand_ready ? rnd_bit : ~hold;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  typedef struct {
    logic [31:0] res;
    int          lat;
    int unsigned acc;
  } exp_t;

  exp_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: RISC-V M-extension semantics plus the documented cycle cost.
  function automatic void ref_model(input logic [1:0] f_op, input logic [31:0] f_a,
                                    input logic [31:0] f_b, output logic [31:0] res,
                                    output int lat);
    logic signed [31:0] sa_v, sb_v;
    bit is_signed, neg_a, neg_b, fix;
    is_signed = (f_op == OP_DIV) || (f_op == OP_REM);
    sa_v = $signed(f_a);
    sb_v = $signed(f_b);
    if (f_b == 0) begin
      res = (f_op == OP_REM || f_op == OP_REMU) ? f_a : 32'hFFFF_FFFF;
      lat = 1;
    end else if (is_signed && f_a == 32'h8000_0000 && f_b == 32'hFFFF_FFFF) begin
      res = (f_op == OP_REM) ? 32'd0 : 32'h8000_0000;
      lat = 1;
    end else if (is_signed) begin
      res   = (f_op == OP_REM) ? 32'(sa_v % sb_v) : 32'(sa_v / sb_v);
      neg_a = sa_v < 0;
      neg_b = sb_v < 0;
      fix   = (f_op == OP_REM) ? neg_a : (neg_a != neg_b);
      lat   = 33 + int'(neg_a) + int'(neg_b) + int'(fix);
    end else begin
      res = (f_op == OP_REMU) ? f_a % f_b : f_a / f_b;
      lat = 33;
    end
  endfunction

  // Monitor: pops the scoreboard on each new response and checks holding.
  bit          in_resp = 0;
  logic [31:0] held = '0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      in_resp = 0;
    end else if (out_valid) begin
      if (!in_resp) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: got result %h with no request outstanding", result);
        end else begin
          e = sb_q.pop_front();
          check32("result", result, e.res);
          check_int("latency", int'(cyc - e.acc) + 1, e.lat);
        end
        in_resp = 1;
        held = result;
      end else begin
        check32("hold_result", result, held);
      end
      check32("done_adder_quiet", add_a | add_b | {31'd0, add_c}, 32'd0);
      if (out_ready) in_resp = 0;
    end else begin
      in_resp = 0;
    end
  end

  task automatic issue(input logic [1:0] f_op, input logic [31:0] f_a, input logic [31:0] f_b,
                       input bit push, output int waited);
    bit rdy;
    logic [31:0] r;
    int l;
    @(negedge clk);
    in_valid = 1'b1;
    op = f_op;
    a = f_a;
    b = f_b;
    waited = 0;
    rdy = in_ready;
    while (!rdy && waited < 500) begin
      @(negedge clk);
      waited++;
      rdy = in_ready;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!rdy) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got no o_ready expected accept within 500 cycles");
    end else if (push) begin
      ref_model(f_op, f_a, f_b, r, l);
      sb_q.push_back('{res: r, lat: l, acc: cyc});
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || !in_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
  endtask

  function automatic logic [31:0] pick_operand();
    unique case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t dir[] = '{
    '{OP_DIVU, 32'd100,        32'd7},
    '{OP_REMU, 32'd100,        32'd7},
    '{OP_DIV,  32'hFFFF_FFF9,  32'd2},
    '{OP_REM,  32'hFFFF_FFF9,  32'd2},
    '{OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE},
    '{OP_DIVU, 32'd5,          32'd0},
    '{OP_REM,  32'd5,          32'd0},
    '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF},
    '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF},
    '{OP_REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFE},
    '{OP_DIV,  32'h8000_0000,  32'd3},
    '{OP_REM,  32'd17,         32'hFFFF_FFFB}
  };

  initial begin
    int w;
    int n;
    // Reset state
    #2;
    check32("reset_ready", {31'd0, in_ready}, 32'd1);
    check32("reset_valid", {31'd0, out_valid}, 32'd0);
    check32("reset_result", result, 32'd0);
    check32("reset_adder", add_a | add_b | {31'd0, add_c}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Directed cases, consumer always ready
    foreach (dir[i]) issue(dir[i].op, dir[i].a, dir[i].b, 1, w);
    drain();

    // Backpressure: hold result for 10 cycles with a request waiting
    hold = 1'b1;
    issue(OP_DIVU, 32'd1000, 32'd3, 1, w);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check32("bp_valid_seen", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1;
    op = OP_DIV;
    a = 32'd77;
    b = 32'd5;
    repeat (10) begin
      @(negedge clk);
      check32("bp_not_ready", {31'd0, in_ready}, 32'd0);
    end
    hold = 1'b0;
    issue(OP_DIVU, 32'd50, 32'd7, 1, w);
    check_int("bp_back_to_back_waits", w, 0);
    drain();

    // Flush and flush-with-valid
    issue(OP_DIVU, 32'h1234_5678, 32'd9, 0, w);
    repeat (15) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check32("flush_idle", {31'd0, in_ready}, 32'd1);
    check32("flush_no_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b1;
    op = OP_DIVU;
    a = 32'd9;
    b = 32'd0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    check32("flush_drops_request", {31'd0, in_ready}, 32'd1);
    repeat (40) @(negedge clk);

    // Asynchronous reset while in NEG_A
    issue(OP_DIV, 32'hFFFF_FF00, 32'd5, 0, w);
    #2;
    reset = 1'b1;
    #1;
    check32("arst_ready", {31'd0, in_ready}, 32'd1);
    check32("arst_valid", {31'd0, out_valid}, 32'd0);
    check32("arst_result", result, 32'd0);
    check32("arst_adder", add_a | add_b | {31'd0, add_c}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd3, 1, w);
    drain();

    // Random operations with random consumer backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 150; k++) begin
      issue(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1, w);
    end
    rand_ready = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check_int("scoreboard_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no completion expected finish before 5ms");
    $fatal(1, "timeout");
  end

endmodule
